// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider slice.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIXUP,
    DONE
  } state_t;

  // Wide enough for any practical WIDTH; users slice [WIDTH-1:0].
  localparam int unsigned MAX_WIDTH = 128;
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module div_lzc
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]               value,
  output logic [cnt_width(WIDTH)-1:0]    count
);

  localparam int unsigned CW = cnt_width(WIDTH);

  // Scan upward so the highest set bit wins.
  always_comb begin
    count = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (quotient + remainder), signed/unsigned per
// request, leading-zero skip, divide-by-zero flag, valid/ready on both sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t state, state_next;

  logic [WIDTH-1:0] araw, amag, dmag, dvd, rem, quo;
  logic             sign_q, sign_r, dz;
  logic [CW-1:0]    cnt, lz;
  logic             sgn, a_neg, d_neg, special;
  logic [WIDTH:0]   rem_sh;

  assign sgn     = SIGNED_EN && signed_mode;
  assign a_neg   = sgn && dividend[WIDTH-1];
  assign d_neg   = sgn && divisor[WIDTH-1];
  assign special = (dmag == '0) || (dmag > amag);
  assign rem_sh  = {rem, dvd[WIDTH-1]};

  div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .value (amag),
    .count (lz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = PREP;
      PREP:    state_next = special ? FIXUP : CALC;
      CALC:    if (cnt == CW'(1)) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araw        <= '0;
      amag        <= '0;
      dmag        <= '0;
      dvd         <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            araw   <= dividend;
            amag   <= a_neg ? -dividend : dividend;
            dmag   <= d_neg ? -divisor : divisor;
            sign_q <= a_neg ^ d_neg;
            sign_r <= a_neg;
          end
        end
        PREP: begin
          dz <= (dmag == '0);
          if (dmag == '0) begin
            quo <= DIV0_QUOTIENT[WIDTH-1:0];
            rem <= araw;
          end else if (dmag > amag) begin
            quo <= '0;
            rem <= amag;
          end else begin
            // Align the dividend MSB so only significant bits are iterated.
            dvd <= amag << lz;
            rem <= '0;
            quo <= '0;
            cnt <= CW'(WIDTH) - lz;
          end
        end
        CALC: begin
          dvd <= dvd << 1;
          cnt <= cnt - CW'(1);
          if (rem_sh >= {1'b0, dmag}) begin
            rem <= WIDTH'(rem_sh - {1'b0, dmag});
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIXUP: begin
          div_by_zero <= dz;
          if (dz) begin
            quotient  <= quo;
            remainder <= rem;
          end else begin
            quotient  <= sign_q ? -quo : quo;
            remainder <= sign_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized bench for seq_divider with an arithmetic reference model and
// directed literal cases.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic         clk, rst_n;
  logic         in_valid, in_ready, signed_mode;
  logic [W-1:0] dividend, divisor;
  logic         out_valid, out_ready;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero, busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  seq_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int unsigned  lat;
    int unsigned  acc;
    logic         seen;
  } exp_t;

  exp_t expq[$];

  // Latency counts cycles after the accept edge: the first cycle after
  // accept is 1, and out_valid must first be visible in cycle lat.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    longint sa, sb, qq, rr;
    longint unsigned ma, mb;
    e.seen = 1'b0;
    e.acc  = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 3;
      return e;
    end
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    qq = sa / sb;
    rr = sa % sb;
    e.q  = qq[W-1:0];
    e.r  = rr[W-1:0];
    e.dz = 1'b0;
    ma = (sa < 0) ? longint'(-sa) : sa;
    mb = (sb < 0) ? longint'(-sb) : sb;
    if (mb > ma) e.lat = 3;
    else         e.lat = 3 + $clog2(ma + 1);
    return e;
  endfunction

  // Compare process: every negedge, check against the model queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        expq.delete();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
      end else begin
        if (out_valid) begin
          if (expq.size() == 0) begin
            chk("unexpected_out_valid", out_valid, 0);
          end else begin
            if (!expq[0].seen) begin
              chk("latency", cyc - expq[0].acc, expq[0].lat);
              expq[0].seen = 1'b1;
            end
            chk("quotient", quotient, expq[0].q);
            chk("remainder", remainder, expq[0].r);
            chk("div_by_zero", div_by_zero, expq[0].dz);
            chk("in_ready_done", in_ready, 0);
            if (out_ready) void'(expq.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          e = model(dividend, divisor, signed_mode);
          e.acc = cyc;
          expq.push_back(e);
        end
      end
    end
  end

  // One request from IDLE; caller is positioned at posedge+1.
  task automatic req(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input int unsigned hold, input logic poke, input logic lit,
                     input logic [W-1:0] eq, input logic [W-1:0] er,
                     input logic edz, input int unsigned elat);
    int unsigned lat;
    chk("in_ready_idle", in_ready, 1);
    dividend = a; divisor = b; signed_mode = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 80) begin
      if (poke) begin
        in_valid = 1'b1; dividend = $urandom; divisor = $urandom; signed_mode = $urandom_range(0, 1);
        chk("in_ready_busy", in_ready, 0);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
    if (lit) begin
      chk("lit_quotient", quotient, eq);
      chk("lit_remainder", remainder, er);
      chk("lit_div_by_zero", div_by_zero, edz);
      chk("lit_latency", lat, elat);
    end
    repeat (hold) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      if (lit) chk("bp_quotient", quotient, eq);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_ack", busy, 0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0:       v = $urandom;
      1:       v = W'($urandom_range(0, 255));
      2:       v = '0;
      3:       v = 32'h8000_0000;
      4:       v = '1;
      5:       v = W'($urandom) >> $urandom_range(0, 31);
      default: v = -(W'($urandom_range(1, 40)));
    endcase
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0;
    signed_mode = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    req(32'd156, 32'd23, 0, 0, 0, 1, 32'd6, 32'd18, 0, 11);
    req(32'd156, 32'd0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'd156, 1, 3);
    req(32'd1, 32'd10421, 0, 0, 0, 1, 32'd0, 32'd1, 0, 3);
    req(32'd0, 32'd1, 0, 0, 0, 1, 32'd0, 32'd0, 0, 3);
    req(32'd1132456, 32'd231352, 0, 0, 0, 1, 32'd4, 32'd207048, 0, 24);
    req(-32'sd7, 32'd2, 1, 0, 0, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 6);
    req(32'd7, -32'sd2, 1, 0, 0, 1, 32'hFFFF_FFFD, 32'd1, 0, 6);
    req(32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0, 1, 32'h8000_0000, 32'd0, 0, 35);
    // Divide-by-zero flag must clear on the next nonzero-divisor result.
    req(-32'sd5, 32'd0, 1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 3);
    req(32'd9, 32'd3, 0, 0, 0, 1, 32'd3, 32'd0, 0, 7);
    // Backpressure with ignored requests while busy.
    req(32'd156, 32'd23, 0, 5, 1, 1, 32'd6, 32'd18, 0, 11);

    // Reset in the middle of CALC.
    dividend = 32'd100000000; divisor = 32'd3; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_mid_calc", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req(32'd100, 32'd7, 0, 0, 0, 1, 32'd14, 32'd2, 0, 10);

    for (int i = 0; i < 300; i++) begin
      req(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), 0, '0, '0, 0, 0);
    end

    repeat (3) @(posedge clk);
    if (expq.size() != 0) chk("pending_results", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle integer divider producing quotient and remainder for WIDTH-bit operands, one quotient bit per cycle. It supports signed and unsigned operation, selected per request, and skips leading zero bits of the dividend to shorten latency. Divide-by-zero is flagged rather than silently mapped. It sits behind a valid/ready request port and in front of a valid/ready result port, for use as a shared execution-unit divider.

## Interface
- WIDTH, 32: operand/result width, ≥4.
- SIGNED_EN, 1: 1 = `signed_mode` honoured; 0 = `signed_mode` ignored and tied to unsigned internally.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- dividend  in  WIDTH  numerator.
- divisor  in  WIDTH  denominator.
- signed_mode  in  1  1 = two's-complement operands.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  result consumer ready.
- quotient  out  WIDTH  registered.
- remainder  out  WIDTH  registered.
- div_by_zero  out  1  registered; set with result when divisor == 0.
- busy  out  1  state != IDLE.

## Operation
- Request handshake: a request is accepted when `in_valid && in_ready`. Operands and `signed_mode` are latched on acceptance. No request is accepted while busy.
- States:
  - IDLE → PREP on accept.
  - PREP → FIXUP on a special case, else → CALC.
  - CALC → FIXUP after n iterations.
  - FIXUP → DONE.
  - DONE → IDLE on `out_ready`.
- At accept:
  - Store magnitudes.
  - Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend). Both are 0 when unsigned.
  - |−2^(WIDTH−1)| is 2^(WIDTH−1) as unsigned.
- PREP:
  - divisor == 0: q = all ones, r = original dividend (no sign fixup on either), `div_by_zero` = 1.
  - |divisor| > |dividend|, which includes dividend == 0: q = 0, r = |dividend|.
  - Otherwise: z = clz(|dividend|), n = WIDTH − z. Shift the dividend left by z, clear the partial remainder, load the counter with n.
- CALC, one iteration per cycle, restoring:
  - rem' = {rem, msb(dvd)}; dvd <<= 1.
  - If rem' ≥ |divisor|: rem = rem' − |divisor| and shift in quotient bit 1.
  - Else: rem = rem' and shift in quotient bit 0.
  - The partial remainder is WIDTH+1 bits wide to avoid compare overflow.
- FIXUP (skipped for the divide-by-zero case):
  - q = sign_q ? −q : q.
  - r = sign_r ? −r : r.
  - Results are truncated to WIDTH.
- Signed overflow −2^(WIDTH−1) / −1 gives q = −2^(WIDTH−1), r = 0, with no flag. This falls out of the magnitude arithmetic and needs no special case.
- Result registers update only on entry to DONE. They hold their values while in IDLE.

## Timing
- Reset values:
  - `out_valid` = 0, `quotient` = 0, `remainder` = 0, `div_by_zero` = 0, `busy` = 0.
  - `in_ready` = 1.
  - State = IDLE.
- Latency from the accept edge to `out_valid` high:
  - 3 cycles on a special-case path.
  - 3 + n cycles otherwise, with 1 ≤ n ≤ WIDTH. Worst case is WIDTH + 3.
- `out_valid` rises on entry to DONE. Outputs stay stable while `out_valid && !out_ready`.
- Result handshake: with `out_valid && out_ready`, return to IDLE next edge; `in_ready` goes high that same edge. Minimum request-to-request spacing is latency + 1.
- `in_valid` while busy: ignored and not queued. The source must hold it.
- `out_ready` is don't-care outside DONE.
- Reset asserted mid-operation: immediate return to IDLE and all outputs take their reset values. The in-flight result is lost.
- `div_by_zero` is valid only while `out_valid` is high. It clears on the next DONE entry that has a nonzero divisor.

## Structure
- Shared package `div_pkg` holds:
  - the state enum (IDLE, PREP, CALC, FIXUP, DONE);
  - the counter-width function clog2(WIDTH+1);
  - the constant DIV0_QUOTIENT = all ones.
- One sub-module, `div_lzc`: a parametrised combinational leading-zero counter used in PREP. It outputs WIDTH when the input is zero.
- Top level holds the FSM, operand/remainder/quotient registers, the iteration counter, and the sign fixup.

## Test plan
- Unsigned 156/23, WIDTH=32: q=6, r=18; `out_valid` 11 cycles after accept (n=8).
- Unsigned 156/0: q=0xFFFFFFFF, r=156, `div_by_zero`=1; latency 3.
- Unsigned 1/10421 and 0/1: q=0, r=1 and q=0, r=0; latency 3. Also 1132456/231352: q=4, r=207048.
- Signed:
  - −7/2 gives q=−3, r=−1.
  - 7/−2 gives q=−3, r=1.
  - 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0, `div_by_zero`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. Outputs are stable and `in_ready`=0. Drive `in_valid` during CALC; it is not accepted.
- Reset: deassert `rst_n` mid-CALC. All outputs return to reset values immediately. A fresh 100/7 then completes with q=14, r=2.
